// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU opcodes and branch types.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 6;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 3'b000;
  localparam alu_op_t ALU_SUB   = 3'b001;
  localparam alu_op_t ALU_AND   = 3'b010;
  localparam alu_op_t ALU_OR    = 3'b011;  // also the bubble op
  localparam alu_op_t ALU_XOR   = 3'b100;
  localparam alu_op_t ALU_SLT   = 3'b101;
  localparam alu_op_t ALU_SLL   = 3'b110;
  localparam alu_op_t ALU_PASSB = 3'b111;

  localparam logic BT_EQ = 1'b0;
  localparam logic BT_LT = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational ALU. zero/lt compare a against b independently of op so the
// branch unit can use them whatever op the decoder selected.
module alu #(
  parameter int W = cpu_pkg::DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         lt
);
  import cpu_pkg::*;

  logic [W-1:0] diff;

  // Compare flags shared by SLT and the branch unit.
  always_comb begin
    diff = a - b;
    zero = (diff == {W{1'b0}});
    lt   = ($signed(a) < $signed(b));
  end

  // Operation select; arithmetic wraps modulo 2^W.
  always_comb begin
    result = {W{1'b0}};
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = diff;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {{(W-1){1'b0}}, lt};
      ALU_SLL:   result = a << b[4:0];
      ALU_PASSB: result = b;
      default:   result = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution with one-cycle redirect,
// wrong-path squash counter and the EX/MEM output register.
module ex_stage #(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int RD_W         = cpu_pkg::RD_W,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_stall,
  input  logic              in_valid,
  input  logic              in_ctrl_regwrt,
  input  logic              in_ctrl_branch,
  input  logic              in_ctrl_btype,
  input  logic              in_ctrl_jump,
  input  logic              in_ctrl_memtoreg,
  input  logic              in_ctrl_memrd,
  input  logic              in_ctrl_memwrt,
  input  logic              in_ctrl_alusrc,
  input  logic [2:0]        in_ctrl_aluop,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_x,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  output logic              out_ctrl_regwrt,
  output logic              out_ctrl_memtoreg,
  output logic              out_ctrl_memrd,
  output logic              out_ctrl_memwrt,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_store,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_redirect,
  output logic [DATA_W-1:0] out_target
);
  import cpu_pkg::*;

  // +2 keeps the counter at least one bit wide for any depth.
  localparam int CNT_W = $clog2(SQUASH_DEPTH + 2);
  localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_DEPTH);

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_lt;
  logic              branch_cond;
  logic              live;
  logic              take;

  logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;
  logic              valid_q, valid_d;
  logic              regwrt_q, regwrt_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memrd_q, memrd_d;
  logic              memwrt_q, memwrt_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] target_q, target_d;

  // Operand B mux: immediate or second register.
  always_comb begin
    op_b = in_ctrl_alusrc ? in_x : in_rt;
  end

  alu #(.W(DATA_W)) u_alu (
    .a      (in_rs),
    .b      (op_b),
    .op     (in_ctrl_aluop),
    .result (alu_res),
    .zero   (alu_zero),
    .lt     (alu_lt)
  );

  // Branch resolution, squash bookkeeping and EX/MEM next-state.
  always_comb begin
    branch_cond = (in_ctrl_btype == BT_LT) ? alu_lt : alu_zero;
    live        = in_valid && (squash_cnt_q == {CNT_W{1'b0}});
    take        = live && (in_ctrl_jump || (in_ctrl_branch && branch_cond));
    // Jump wins over branch when both are set.
    target_d    = in_ctrl_jump ? in_rs : (in_pc + in_x);
    redirect_d  = take;

    if (take) begin
      squash_cnt_d = SQ_LOAD;
    end else if (squash_cnt_q != {CNT_W{1'b0}}) begin
      squash_cnt_d = squash_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      squash_cnt_d = squash_cnt_q;
    end

    // Data fields load unconditionally; only control is gated by live.
    valid_d    = live;
    regwrt_d   = live && in_ctrl_regwrt;
    memtoreg_d = live && in_ctrl_memtoreg;
    memrd_d    = live && in_ctrl_memrd;
    memwrt_d   = live && in_ctrl_memwrt;
    alu_d      = alu_res;
    store_d    = in_rt;
    rd_d       = in_rd;
  end

  // EX/MEM register: reset beats stall; stall holds all but the redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt_q <= {CNT_W{1'b0}};
      valid_q      <= 1'b0;
      regwrt_q     <= 1'b0;
      memtoreg_q   <= 1'b0;
      memrd_q      <= 1'b0;
      memwrt_q     <= 1'b0;
      alu_q        <= {DATA_W{1'b0}};
      store_q      <= {DATA_W{1'b0}};
      rd_q         <= {RD_W{1'b0}};
      redirect_q   <= 1'b0;
      target_q     <= {DATA_W{1'b0}};
    end else if (in_stall) begin
      redirect_q   <= 1'b0;
    end else begin
      squash_cnt_q <= squash_cnt_d;
      valid_q      <= valid_d;
      regwrt_q     <= regwrt_d;
      memtoreg_q   <= memtoreg_d;
      memrd_q      <= memrd_d;
      memwrt_q     <= memwrt_d;
      alu_q        <= alu_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      redirect_q   <= redirect_d;
      target_q     <= target_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_ctrl_regwrt   = regwrt_q;
  assign out_ctrl_memtoreg = memtoreg_q;
  assign out_ctrl_memrd    = memrd_q;
  assign out_ctrl_memwrt   = memwrt_q;
  assign out_alu           = alu_q;
  assign out_store         = store_q;
  assign out_rd            = rd_q;
  assign out_redirect      = redirect_q;
  assign out_target        = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected EX/MEM contents,
// a monitor pops and compares once per clock.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_stall = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ctrl_regwrt = 1'b0, in_ctrl_branch = 1'b0, in_ctrl_btype = 1'b0;
  logic        in_ctrl_jump = 1'b0, in_ctrl_memtoreg = 1'b0, in_ctrl_memrd = 1'b0;
  logic        in_ctrl_memwrt = 1'b0, in_ctrl_alusrc = 1'b0;
  logic [2:0]  in_ctrl_aluop = 3'b011;
  logic [31:0] in_pc = 32'd0, in_rs = 32'd0, in_rt = 32'd0, in_x = 32'd0;
  logic [5:0]  in_rd = 6'd0;
  logic        out_valid, out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt;
  logic [31:0] out_alu, out_store, out_target;
  logic [5:0]  out_rd;
  logic        out_redirect;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_stall(in_stall), .in_valid(in_valid),
    .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_branch(in_ctrl_branch),
    .in_ctrl_btype(in_ctrl_btype), .in_ctrl_jump(in_ctrl_jump),
    .in_ctrl_memtoreg(in_ctrl_memtoreg), .in_ctrl_memrd(in_ctrl_memrd),
    .in_ctrl_memwrt(in_ctrl_memwrt), .in_ctrl_alusrc(in_ctrl_alusrc),
    .in_ctrl_aluop(in_ctrl_aluop), .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt),
    .in_x(in_x), .in_rd(in_rd),
    .out_valid(out_valid), .out_ctrl_regwrt(out_ctrl_regwrt),
    .out_ctrl_memtoreg(out_ctrl_memtoreg), .out_ctrl_memrd(out_ctrl_memrd),
    .out_ctrl_memwrt(out_ctrl_memwrt), .out_alu(out_alu), .out_store(out_store),
    .out_rd(out_rd), .out_redirect(out_redirect), .out_target(out_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, regwrt, memtoreg, memrd, memwrt;
    logic [31:0] alu, store;
    logic [5:0]  rd;
    logic        redirect;
    logic        tgt_known;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_prev = '0;
  int   m_discard = 0;   // wrong-path instructions still to be dropped
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return b;
    endcase
  endfunction

  // Reference model for one clock edge using the current inputs.
  task automatic model_step();
    exp_t e;
    logic [31:0] b;
    logic live, taken;
    if (rst) begin
      e = '0;
      e.tgt_known = 1'b1;
      m_discard = 0;
    end else if (in_stall) begin
      e = m_prev;
      e.redirect = 1'b0;
    end else begin
      b = in_ctrl_alusrc ? in_x : in_rt;
      live = in_valid && (m_discard == 0);
      taken = live && (in_ctrl_jump ||
              (in_ctrl_branch && (in_ctrl_btype ? ($signed(in_rs) < $signed(b)) : (in_rs == b))));
      e = '0;
      e.valid    = live;
      e.regwrt   = live & in_ctrl_regwrt;
      e.memtoreg = live & in_ctrl_memtoreg;
      e.memrd    = live & in_ctrl_memrd;
      e.memwrt   = live & in_ctrl_memwrt;
      e.alu      = ref_alu(in_ctrl_aluop, in_rs, b);
      e.store    = in_rt;
      e.rd       = in_rd;
      e.redirect = taken;
      e.tgt_known = taken;
      e.target   = in_ctrl_jump ? in_rs : in_pc + in_x;
      if (taken) m_discard = 2;
      else if (m_discard > 0) m_discard--;
    end
    m_prev = e;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic s);
    @(negedge clk);
    rst = r;
    in_stall = s;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic src, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] x, input logic [5:0] rd,
                           input logic rw);
    in_valid = 1'b1; in_ctrl_aluop = op; in_ctrl_alusrc = src;
    in_rs = rs; in_rt = rt; in_x = x; in_rd = rd; in_ctrl_regwrt = rw;
    in_ctrl_branch = 1'b0; in_ctrl_btype = 1'b0; in_ctrl_jump = 1'b0;
    in_ctrl_memtoreg = 1'b0; in_ctrl_memrd = 1'b0; in_ctrl_memwrt = 1'b0;
    in_pc = 32'd0;
  endtask

  // Monitor: one EX/MEM slot per clock, compared against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_valid",    {31'd0, out_valid},         {31'd0, mon_e.valid});
      check("sb_regwrt",   {31'd0, out_ctrl_regwrt},   {31'd0, mon_e.regwrt});
      check("sb_memtoreg", {31'd0, out_ctrl_memtoreg}, {31'd0, mon_e.memtoreg});
      check("sb_memrd",    {31'd0, out_ctrl_memrd},    {31'd0, mon_e.memrd});
      check("sb_memwrt",   {31'd0, out_ctrl_memwrt},   {31'd0, mon_e.memwrt});
      check("sb_alu",      out_alu,                    mon_e.alu);
      check("sb_store",    out_store,                  mon_e.store);
      check("sb_rd",       {26'd0, out_rd},            {26'd0, mon_e.rd});
      check("sb_redirect", {31'd0, out_redirect},      {31'd0, mon_e.redirect});
      if (mon_e.tgt_known) check("sb_target", out_target, mon_e.target);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu", out_alu, 32'd0);

    // ADD with immediate
    set_instr(3'b000, 1'b1, 32'd5, 32'd0, 32'd7, 6'd3, 1'b1);
    cyc(1'b0, 1'b0);
    check("add_alu", out_alu, 32'd12);
    check("add_rd", {26'd0, out_rd}, 32'd3);
    check("add_regwrt", {31'd0, out_ctrl_regwrt}, 32'd1);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_redirect", {31'd0, out_redirect}, 32'd0);

    // SLT signed, SUB wraparound
    set_instr(3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'd4, 1'b1);
    cyc(1'b0, 1'b0);
    check("slt_alu", out_alu, 32'd1);
    set_instr(3'b001, 1'b0, 32'd3, 32'd5, 32'd0, 6'd5, 1'b1);
    cyc(1'b0, 1'b0);
    check("sub_alu", out_alu, 32'hFFFF_FFFE);

    // BEQ taken, then two squashed, third live
    set_instr(3'b001, 1'b0, 32'd9, 32'd9, 32'h10, 6'd0, 1'b0);
    in_ctrl_branch = 1'b1; in_pc = 32'h40;
    cyc(1'b0, 1'b0);
    check("beq_redirect", {31'd0, out_redirect}, 32'd1);
    check("beq_target", out_target, 32'h50);
    set_instr(3'b000, 1'b1, 32'd1, 32'd0, 32'd1, 6'd7, 1'b1);
    cyc(1'b0, 1'b0);
    check("beq_pulse_end", {31'd0, out_redirect}, 32'd0);
    check("sq1_valid", {31'd0, out_valid}, 32'd0);
    check("sq1_regwrt", {31'd0, out_ctrl_regwrt}, 32'd0);
    cyc(1'b0, 1'b0);
    check("sq2_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0);
    check("post_sq_valid", {31'd0, out_valid}, 32'd1);

    // BLT not taken
    set_instr(3'b001, 1'b0, 32'd4, 32'd2, 32'h20, 6'd0, 1'b0);
    in_ctrl_branch = 1'b1; in_ctrl_btype = 1'b1;
    cyc(1'b0, 1'b0);
    check("blt_nt_redirect", {31'd0, out_redirect}, 32'd0);
    set_instr(3'b000, 1'b1, 32'd2, 32'd0, 32'd2, 6'd8, 1'b1);
    cyc(1'b0, 1'b0);
    check("blt_next_valid", {31'd0, out_valid}, 32'd1);

    // Jump followed by a 3-cycle stall
    set_instr(3'b011, 1'b0, 32'h200, 32'd0, 32'd0, 6'd0, 1'b0);
    in_ctrl_jump = 1'b1;
    cyc(1'b0, 1'b0);
    check("jmp_redirect", {31'd0, out_redirect}, 32'd1);
    check("jmp_target", out_target, 32'h200);
    set_instr(3'b000, 1'b1, 32'd1, 32'd0, 32'd1, 6'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      check("stall_redirect", {31'd0, out_redirect}, 32'd0);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_target", out_target, 32'h200);
    end
    cyc(1'b0, 1'b0);
    check("jsq1_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0);
    check("jsq2_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0);
    check("jpost_valid", {31'd0, out_valid}, 32'd1);

    // Reset mid-squash (right after a taken branch, and one cycle into squash)
    for (int k = 0; k < 2; k++) begin
      set_instr(3'b001, 1'b0, 32'd6, 32'd6, 32'h8, 6'd0, 1'b0);
      in_ctrl_branch = 1'b1; in_pc = 32'h100;
      cyc(1'b0, 1'b0);
      set_instr(3'b000, 1'b1, 32'd10, 32'd3, 32'd20, 6'd11, 1'b1);
      if (k == 1) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      check("rst_sq_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sq_alu", out_alu, 32'd0);
      check("rst_sq_target", out_target, 32'd0);
      check("rst_sq_store", out_store, 32'd0);
      cyc(1'b0, 1'b0);
      check("rst_sq_live", {31'd0, out_valid}, 32'd1);
      check("rst_sq_add", out_alu, 32'd30);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid         = ($urandom_range(7, 0) != 0);
      in_ctrl_aluop    = 3'($urandom_range(7, 0));
      in_ctrl_alusrc   = 1'($urandom_range(1, 0));
      in_rs            = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(15, 0)) : $urandom;
      in_rt            = ($urandom_range(3, 0) == 0) ? in_rs : $urandom;
      in_x             = ($urandom_range(1, 0) == 0) ? 32'($urandom_range(255, 0)) : $urandom;
      in_pc            = $urandom;
      in_rd            = 6'($urandom_range(63, 0));
      in_ctrl_branch   = ($urandom_range(4, 0) == 0);
      in_ctrl_btype    = 1'($urandom_range(1, 0));
      in_ctrl_jump     = ($urandom_range(9, 0) == 0);
      in_ctrl_regwrt   = 1'($urandom_range(1, 0));
      in_ctrl_memtoreg = 1'($urandom_range(1, 0));
      in_ctrl_memrd    = 1'($urandom_range(1, 0));
      in_ctrl_memwrt   = 1'($urandom_range(1, 0));
      cyc(($urandom_range(59, 0) == 0), ($urandom_range(5, 0) == 0));
    end

    @(posedge clk);
    #2;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
